sd_dat_xfer_ctrl: RTL

- Transfer sequencer for the SD host data path.
- Takes a transfer request (direction, bus mode, block count) from the host register side and drives the DAT engine's `new_trans`, `mode`, `direction` and FIFO-enable controls.
- Throttles the card clock against the asynchronous FIFO's almost-full and almost-empty flags.
- Counts blocks, checks per-block CRC status and enforces a data timeout.
- Reports done or error back to the host.

---
 rtl/sd_dat_xfer_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sd_dat_xfer_ctrl.sv
// SD host data transfer sequencer: arms the DAT engine per block,
// throttles the card clock on FIFO flags, tracks CRC and timeouts.
module sd_dat_xfer_ctrl #(
    parameter int          TIMEOUT_W   = 16,
    parameter int unsigned TIMEOUT_CYC = 16'hFFFF,
    parameter int unsigned GAP_CYC     = 2
) (
    input  logic        clk,
    input  logic        reset_input,
    input  logic        start,
    input  logic        abort,
    input  logic        direction,
    input  logic        mode,
    input  logic [10:0] block_amount,
    input  logic        fifo_full,
    input  logic        fifo_empty,
    input  logic        fifo_ready,
    input  logic        blk_done,
    input  logic        crc_ok,
    input  logic        busy_release,
    output logic        new_trans,
    output logic        dat_direction,
    output logic        dat_mode,
    output logic        dat_fifo_en,
    output logic        card_clk_stop,
    output logic [10:0] blocks_left,
    output logic        busy,
    output logic        xfer_done,
    output logic        xfer_error,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {
        IDLE, ARM, WAIT_FIFO, XFER, GAP, BUSY_WAIT, DONE, ERROR
    } state_t;

    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);
    localparam logic [TIMEOUT_W-1:0] GAP_LAST = TIMEOUT_W'(GAP_CYC - 1);

    state_t               state, state_nxt;
    logic [TIMEOUT_W-1:0] tcnt;
    logic [1:0]           code_nxt;
    logic                 fifo_stall, fifo_go, tmo_hit, accept, blk_ok;

    // The stall flag depends on which side of the FIFO the card feeds.
    assign fifo_stall = dat_direction ? fifo_empty : fifo_full;
    assign fifo_go    = fifo_ready && !fifo_stall;
    assign tmo_hit    = (tcnt == TMO_LAST);
    assign accept     = (state == IDLE) && start && (block_amount != '0);
    assign blk_ok     = blk_done && crc_ok;

    always_comb begin
        state_nxt = state;
        code_nxt  = err_code;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ARM;
                    code_nxt  = 2'd0;
                end else if (start) begin
                    state_nxt = ERROR;
                    code_nxt  = 2'd3;
                end
            end
            ARM:       state_nxt = WAIT_FIFO;
            WAIT_FIFO: if (fifo_go) state_nxt = XFER;
            XFER: begin
                if (blk_done && !crc_ok) begin
                    state_nxt = ERROR;
                    code_nxt  = 2'd1;
                end else if (blk_ok) begin
                    if (blocks_left == 11'd1)
                        state_nxt = dat_direction ? BUSY_WAIT : DONE;
                    else
                        state_nxt = GAP;
                end else if (!card_clk_stop && tmo_hit) begin
                    state_nxt = ERROR;
                    code_nxt  = 2'd2;
                end
            end
            GAP:       if (tcnt == GAP_LAST) state_nxt = WAIT_FIFO;
            BUSY_WAIT: begin
                if (busy_release) begin
                    state_nxt = DONE;
                end else if (tmo_hit) begin
                    state_nxt = ERROR;
                    code_nxt  = 2'd2;
                end
            end
            DONE:      state_nxt = IDLE;
            ERROR:     state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        // Abort outranks any block completion or timeout in the same cycle.
        if (abort && !(state inside {IDLE, DONE, ERROR})) begin
            state_nxt = ERROR;
            code_nxt  = 2'd3;
        end
    end

    always_ff @(posedge clk or posedge reset_input) begin
        if (reset_input) begin
            state         <= IDLE;
            tcnt          <= '0;
            new_trans     <= 1'b0;
            dat_direction <= 1'b0;
            dat_mode      <= 1'b0;
            dat_fifo_en   <= 1'b0;
            card_clk_stop <= 1'b0;
            blocks_left   <= '0;
            busy          <= 1'b0;
            xfer_done     <= 1'b0;
            xfer_error    <= 1'b0;
            err_code      <= 2'd0;
        end else begin
            state         <= state_nxt;
            err_code      <= code_nxt;
            busy          <= (state_nxt != IDLE);
            new_trans     <= (state_nxt == XFER) && (state != XFER);
            dat_fifo_en   <= (state_nxt == XFER);
            card_clk_stop <= (state_nxt == XFER) && fifo_stall;
            xfer_done     <= (state_nxt == DONE);
            if (accept)
                xfer_error <= 1'b0;
            else if (state_nxt == ERROR)
                xfer_error <= 1'b1;
            if (state == ARM) begin
                dat_direction <= direction;
                dat_mode      <= mode;
                blocks_left   <= block_amount;
            end else if (state == XFER && blk_ok && state_nxt != ERROR) begin
                blocks_left <= blocks_left - 11'd1;
            end
            // One counter serves the gap length and both timeout windows.
            if (state_nxt != state)
                tcnt <= '0;
            else if (state == GAP || state == BUSY_WAIT ||
                     (state == XFER && !card_clk_stop))
                tcnt <= tcnt + TIMEOUT_W'(1);
        end
    end

endmodule
